// File: rtl/uart_sample_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_sample_rx : 8N1 UART receiver that rebuilds tagged 12-bit samples    |
// | Optional macro UART_SAMPLE_RX_PARITY_EN: 8E1 framing plus parity_err.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module uart_sample_rx #(
    parameter int         CLK_FREQ = 50000000,
    parameter int         BAUD     = 9600,
    parameter logic [3:0] TAG      = 4'hA,
    parameter int         GAP_BITS = 20
) (
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [11:0] data_out,
    output logic        valid,
    output logic        frame_err,
    output logic        tag_err,
    output logic        gap_err,
`ifdef UART_SAMPLE_RX_PARITY_EN
    output logic        parity_err,
`endif
    output logic        busy
);
    localparam int DIV     = CLK_FREQ / BAUD;
    localparam int GAP_MAX = GAP_BITS * DIV;
    localparam int CW      = $clog2(DIV) + 1;
    localparam int GW      = $clog2(GAP_MAX) + 1;

    localparam logic [CW-1:0] C_HALF     = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] C_FULL     = CW'(DIV - 1);
    localparam logic [GW-1:0] C_GAP_LAST = GW'(GAP_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } bit_state_t;

    typedef enum logic [0:0] {
        A_EXP_HI = 1'b0,
        A_EXP_LO = 1'b1
    } asm_state_t;

    logic            r_rx_meta;
    logic            r_rx_s;
    bit_state_t      r_state;
    bit_state_t      w_next;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shreg;
    logic            r_rearm;
    asm_state_t      r_asm;
    asm_state_t      w_asm_next;
    logic [3:0]      r_hi_nib;
    logic [GW-1:0]   r_gap_cnt;
    logic [11:0]     r_data;
    logic            r_valid;
    logic            r_frame;
    logic            r_tag;
    logic            r_gap;

    logic            w_start;
    logic            w_half;
    logic            w_full;
    logic            w_stop_smp;
    logic            w_frame;
    logic            w_par_bad;
    logic            w_byte_done;
    logic            w_gap_hit;
    logic            w_valid_nx;
    logic            w_tag_nx;

`ifdef UART_SAMPLE_RX_PARITY_EN
    logic            r_par;
    logic            r_parity;
    assign w_par_bad  = w_stop_smp && r_rx_s && (^{r_shreg, r_par});
    assign parity_err = r_parity;
`else
    assign w_par_bad  = 1'b0;
`endif

    // A low rx_s after a framing error is the bad stop bit itself, not a new start.
    assign w_start     = (r_state == S_IDLE) && !r_rearm && !r_rx_s;
    assign w_half      = (r_cnt == C_HALF);
    assign w_full      = (r_cnt == C_FULL);
    assign w_stop_smp  = (r_state == S_STOP) && w_full;
    assign w_frame     = w_stop_smp && !r_rx_s;
    assign w_byte_done = w_stop_smp && r_rx_s && !w_par_bad;
    assign w_gap_hit   = (r_asm == A_EXP_LO) && (r_state == S_IDLE) && !w_start
                         && (r_gap_cnt == C_GAP_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next = S_START;
            S_START:  if (w_half) w_next = r_rx_s ? S_IDLE : S_DATA;
`ifdef UART_SAMPLE_RX_PARITY_EN
            S_DATA:   if (w_full && (r_bit_idx == 3'd7)) w_next = S_PARITY;
            S_PARITY: if (w_full) w_next = S_STOP;
`else
            S_DATA:   if (w_full && (r_bit_idx == 3'd7)) w_next = S_STOP;
`endif
            S_STOP:   if (w_full) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_asm_next = r_asm;
        w_valid_nx = 1'b0;
        w_tag_nx   = 1'b0;
        if (w_frame || w_par_bad || w_gap_hit) begin
            w_asm_next = A_EXP_HI;
        end else if (w_byte_done) begin
            if (r_asm == A_EXP_HI) begin
                if (r_shreg[7:4] == TAG) w_asm_next = A_EXP_LO;
                else                     w_tag_nx   = 1'b1;
            end else begin
                w_asm_next = A_EXP_HI;
                w_valid_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
            r_rearm   <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_state   <= w_next;
            if ((r_state != w_next) || ((r_state == S_DATA) && w_full))
                r_cnt <= '0;
            else if (!w_full)
                r_cnt <= r_cnt + 1'b1;
            if (w_start)
                r_bit_idx <= '0;
            else if ((r_state == S_DATA) && w_full) begin
                r_bit_idx <= r_bit_idx + 1'b1;
                r_shreg   <= {r_rx_s, r_shreg[7:1]};
            end
            if (w_frame)     r_rearm <= 1'b1;
            else if (r_rx_s) r_rearm <= 1'b0;
        end
    end

`ifdef UART_SAMPLE_RX_PARITY_EN
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_par    <= 1'b0;
            r_parity <= 1'b0;
        end else begin
            if ((r_state == S_PARITY) && w_full) r_par <= r_rx_s;
            r_parity <= w_par_bad;
        end
    end
`endif

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_asm     <= A_EXP_HI;
            r_hi_nib  <= '0;
            r_gap_cnt <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_frame   <= 1'b0;
            r_tag     <= 1'b0;
            r_gap     <= 1'b0;
        end else begin
            r_asm   <= w_asm_next;
            r_valid <= w_valid_nx;
            r_tag   <= w_tag_nx;
            r_frame <= w_frame;
            r_gap   <= w_gap_hit;
            if (w_byte_done && (r_asm == A_EXP_HI)) r_hi_nib <= r_shreg[3:0];
            if (w_valid_nx) r_data <= {r_hi_nib, r_shreg};
            if ((r_asm != A_EXP_LO) || w_start)
                r_gap_cnt <= '0;
            else if ((r_state == S_IDLE) && (r_gap_cnt != C_GAP_LAST))
                r_gap_cnt <= r_gap_cnt + 1'b1;
        end
    end

    assign data_out  = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame;
    assign tag_err   = r_tag;
    assign gap_err   = r_gap;
    assign busy      = (r_state != S_IDLE) || (r_asm == A_EXP_LO);

endmodule
`default_nettype wire

// File: tb/tb_uart_sample_rx.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_uart_sample_rx : scoreboard bench for uart_sample_rx at DIV = 434       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_uart_sample_rx;
    localparam int CLK_FREQ = 50000000;
    localparam int BAUD     = 115200;
    localparam int DIV      = CLK_FREQ / BAUD;

    localparam int K_VALID  = 1;
    localparam int K_FRAME  = 2;
    localparam int K_TAG    = 3;
    localparam int K_GAP    = 4;
    localparam int K_PARITY = 5;

    typedef struct {
        int         kind;
        logic [11:0] data;
    } ev_t;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic [11:0] data_out;
    logic        valid;
    logic        frame_err;
    logic        tag_err;
    logic        gap_err;
    logic        busy;
    logic        par_err;

    ev_t sb[$];
    int  checks = 0;
    int  errors = 0;

    uart_sample_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .TAG      (4'hA),
        .GAP_BITS (20)
    ) u_dut (
        .sysclk    (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .tag_err   (tag_err),
        .gap_err   (gap_err),
`ifdef UART_SAMPLE_RX_PARITY_EN
        .parity_err(par_err),
`endif
        .busy      (busy)
    );

`ifndef UART_SAMPLE_RX_PARITY_EN
    assign par_err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [11:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic bit_period(input logic v);
        rx = v;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v, input logic par_flip);
        logic pbit;
        pbit = (^b) ^ par_flip;
        bit_period(1'b0);
        for (int i = 0; i < 8; i++) bit_period(b[i]);
`ifdef UART_SAMPLE_RX_PARITY_EN
        bit_period(pbit);
`endif
        bit_period(stop_v);
    endtask

    // Monitor: every strobe cycle consumes exactly one scoreboard entry.
    always @(negedge clk) begin : mon
        int  n;
        int  k;
        ev_t e;
        if (rst_n) begin
            n = int'(valid) + int'(frame_err) + int'(tag_err) + int'(gap_err) + int'(par_err);
            if (n != 0) begin
                k = valid ? K_VALID : frame_err ? K_FRAME : tag_err ? K_TAG :
                    gap_err ? K_GAP : K_PARITY;
                checks++;
                if (n > 1) begin
                    errors++;
                    $display("FAIL strobe_excl: %0d strobes at once, required 1", n);
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: kind %0d data %03h, required none", k, data_out);
                end else begin
                    e = sb.pop_front();
                    if ((e.kind != k) || ((k == K_VALID) && (e.data != data_out))) begin
                        errors++;
                        $display("FAIL event: kind %0d data %03h, required kind %0d data %03h",
                                 k, data_out, e.kind, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    task automatic check_all_zero(input string name);
        check({name, "_data"}, data_out, 0);
        check({name, "_strobes"}, {valid, frame_err, tag_err, gap_err, par_err}, 0);
        check({name, "_busy"}, busy, 0);
    endtask

    initial begin
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Plain sample decode
        push(K_VALID, 12'h5F3);
        send_byte(8'hA5, 1'b1, 1'b0);
        bit_period(1'b1);
        send_byte(8'hF3, 1'b1, 1'b0);
        bit_period(1'b1);
        check("decode_busy", busy, 0);
        check("decode_data", data_out, 12'h5F3);

        // Two tag failures in a row
        push(K_TAG, 12'h000);
        push(K_TAG, 12'h000);
        send_byte(8'h35, 1'b1, 1'b0);
        send_byte(8'hF3, 1'b1, 1'b0);
        bit_period(1'b1);
        check("badtag_busy", busy, 0);
        check("badtag_data", data_out, 12'h5F3);

        // Short glitch
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        check("glitch_busy", busy, 0);

        // Framing error then recovery
        push(K_FRAME, 12'h000);
        send_byte(8'hA5, 1'b0, 1'b0);
        bit_period(1'b1);
        check("frame_busy", busy, 0);
        push(K_VALID, 12'h100);
        send_byte(8'hA1, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        bit_period(1'b1);
        check("frame_recover_data", data_out, 12'h100);

        // Inter-byte gap timeout
        push(K_GAP, 12'h000);
        push(K_TAG, 12'h000);
        send_byte(8'hA7, 1'b1, 1'b0);
        check("gap_wait_busy", busy, 1);
        repeat (19) bit_period(1'b1);
        check("gap_not_yet", busy, 1);
        repeat (2) bit_period(1'b1);
        check("gap_fired_busy", busy, 0);
        send_byte(8'h22, 1'b1, 1'b0);
        bit_period(1'b1);
        check("gap_data_kept", data_out, 12'h100);

        // Reset during bit 4 of a low byte
        send_byte(8'hA5, 1'b1, 1'b0);
        bit_period(1'b0);
        for (int i = 0; i < 4; i++) bit_period(i < 2);
        rx = 1'b1;
        repeat (DIV / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("midreset");
        rst_n = 1'b1;
        bit_period(1'b1);
        check("midreset_idle_busy", busy, 0);
        push(K_VALID, 12'hFFF);
        send_byte(8'hAF, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        bit_period(1'b1);
        check("after_reset_data", data_out, 12'hFFF);

        // Back-to-back samples
        push(K_VALID, 12'h000);
        push(K_VALID, 12'hFFF);
        send_byte(8'hA0, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'hAF, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        bit_period(1'b1);
        check("b2b_data", data_out, 12'hFFF);
        check("b2b_busy", busy, 0);

`ifdef UART_SAMPLE_RX_PARITY_EN
        push(K_PARITY, 12'h000);
        send_byte(8'hA0, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b1);
        bit_period(1'b1);
        check("parity_busy", busy, 0);
        check("parity_data_kept", data_out, 12'hFFF);
`endif

        repeat (DIV) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
